multi_phase_signal_ctrl: RTL
============================

# multi_phase_signal_ctrl

Parametrised N-phase intersection signal controller that generalises the two-road highway/side-road controller to any number of conflicting phases. It has per-phase demand latching, minimum and maximum green, configurable yellow and all-red clearance, and round-robin service of pending phases. Phase 0 is the rest phase after reset. An optional emergency preemption input forces a chosen phase to green through a safe clearance.

## Interface

- `NUM_PHASES`, 4: number of mutually exclusive phases; must be ≥2.
- `GREEN_MIN`, 5: minimum green cycles per phase; must be ≥1.
- `GREEN_MAX`, 20: maximum green cycles while another phase is pending; must be ≥ `GREEN_MIN`.
- `YELLOW_TIME`, 4: yellow cycles; must be ≥1.
- `ALLRED_TIME`, 2: all-red clearance cycles; must be ≥1.
- `TW`, 8: timer width; all times must be ≤ 2^TW.
- `clk`  in  1  clock; the block uses this single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `demand`  in  NUM_PHASES  per-phase vehicle/request sensor, level or pulse.
- `lights`  out  2*NUM_PHASES  per-phase light; bits [2i+1:2i] belong to phase i. Encoding: RED=0, YELLOW=1, GREEN=2.
- `active_phase`  out  $clog2(NUM_PHASES)  phase currently green/yellow, or the phase just cleared during all-red.
- `stage`  out  2  0=GREEN, 1=YELLOW, 2=ALL_RED.
- `pending`  out  NUM_PHASES  latched unserved requests.
- `preempt`  in  1  emergency request. Present only with `SIGNAL_PREEMPT_EN`.
- `preempt_phase`  in  $clog2(NUM_PHASES)  phase to force green. Present only with `SIGNAL_PREEMPT_EN`.

## Operation

- **Reset:**
  - stage=GREEN, active_phase=0, timer=0, pending=0.
  - lights: phase 0 GREEN, all others RED.
- **Timer:**
  - The timer clears to 0 on every stage change and increments otherwise.
  - In GREEN the timer saturates at GREEN_MAX-1.
- **Pending latch:** each cycle, pending[i] <= pending[i] | (demand[i] & ~(stage==GREEN && active_phase==i)).
  - The bit for the phase entering GREEN is cleared on that entry cycle.
  - If set and clear occur in the same cycle, clear wins.
- **GREEN → YELLOW:** occurs when timer ≥ GREEN_MIN-1, any other pending bit is set, and either demand[active_phase]==0 or timer==GREEN_MAX-1.
  - With nothing pending elsewhere, the current phase rests in GREEN indefinitely.
- **YELLOW → ALL_RED:** occurs at timer==YELLOW_TIME-1.
- **ALL_RED → GREEN:** occurs at timer==ALLRED_TIME-1.
  - The next phase is the first pending phase searching active_phase+1, +2, … with wrap modulo NUM_PHASES.
  - If no phase is pending, the next phase is 0.
- **Lights:** decoded combinationally from registered stage/active_phase.
  - Exactly one phase is non-RED in GREEN and YELLOW.
  - All phases are RED in ALL_RED.
  - Two phases are never non-RED in the same cycle.
- **Illegal stage encoding:** returns the block to the reset state on the next cycle.

## Timing

- Demand asserted in cycle t is visible in `pending` at t+1.
- The GREEN exit decision uses the registered pending value.
- Every green lasts at least GREEN_MIN cycles.
- With competing demand, green lasts at most GREEN_MAX cycles (without preemption).
- YELLOW lasts exactly YELLOW_TIME cycles; ALL_RED lasts exactly ALLRED_TIME cycles.
- Minimum phase-to-phase turnaround is GREEN_MIN+YELLOW_TIME+ALLRED_TIME cycles.
- `rst` asserted in any stage, including mid-YELLOW or mid-ALL_RED, takes effect at the next edge: phase 0 GREEN, pending cleared.

## Configuration

- **`SIGNAL_PREEMPT_EN` defined:** `preempt`/`preempt_phase` ports exist.
  - While preempt=1 and active_phase≠preempt_phase in GREEN: go to YELLOW on the next edge, ignoring GREEN_MIN.
  - YELLOW and ALL_RED always complete their full times.
  - The ALL_RED exit selects preempt_phase instead of round-robin.
  - While preempt=1 and preempt_phase is GREEN, the block holds GREEN and ignores GREEN_MAX and other pending phases.
  - When preempt drops, normal rules resume with the timer value as it stands.
  - preempt_phase ≥ NUM_PHASES is treated as no preemption.
- **Not defined:** the ports are absent and behaviour is purely demand-driven.

## Test plan

Defaults apply throughout (4 phases, 5/20/4/2).

1. **Idle rest:** reset, then 100 cycles of demand=0 -> lights=8'b00000010 for the whole run, stage=0, pending=0.
2. **Minimum green:** demand[2] pulsed for 1 cycle immediately after reset -> phase 0 GREEN for 5 cycles, YELLOW for 4, all RED for 2, then phase 2 GREEN and pending[2]=0.
3. **Maximum green:** phase 1 GREEN with demand[1] held high and demand[3] pulsed -> phase 1 GREEN for exactly 20 cycles, then YELLOW.
4. **Round robin:** phase 2 GREEN, demand[1] and demand[3] both pulsed -> service order is 3, then 1; phase 0 is skipped.
5. **Reset mid-clearance:** rst asserted on the 2nd YELLOW cycle -> next cycle phase 0 GREEN, pending=0, timer=0.
6. **Preemption (SIGNAL_PREEMPT_EN):** preempt=1, preempt_phase=3 at timer=1 of phase 1 GREEN -> YELLOW next cycle, 4+2 clearance cycles, phase 3 GREEN held for 50 cycles despite pending[0]=1.
   - After preempt drops, phase 3 exits once GREEN_MIN is met.

Source files
------------

// File: rtl/multi_phase_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_signal_ctrl
// Brief    : N-phase intersection signal controller. It latches demand per
//            phase and enforces minimum and maximum green times. Each green
//            is followed by a yellow stage and an all-red clearance stage.
//            Pending phases are served round-robin, and phase 0 is the rest
//            phase after reset.
//            Optional emergency preemption is built when the macro
//            SIGNAL_PREEMPT_EN is defined. It adds the ports preempt and
//            preempt_phase.
// Revision : 1.0 - initial release
// ============================================================================
module multi_phase_signal_ctrl #(
  parameter int NUM_PHASES  = 4,
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 20,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int TW          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         demand,
`ifdef SIGNAL_PREEMPT_EN
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
`endif
  output logic [2*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [1:0]                    stage,
  output logic [NUM_PHASES-1:0]         pending
);

  localparam int PW = $clog2(NUM_PHASES);

  // Last timer value of each timed stage
  localparam logic [TW-1:0] C_GMIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] C_GMAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] C_Y_LAST    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] C_AR_LAST   = TW'(ALLRED_TIME - 1);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } stage_e;

  stage_e                  stage_q, stage_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [NUM_PHASES-1:0]   pending_q, pending_d;

  logic [NUM_PHASES-1:0]   w_phase_onehot;
  logic [NUM_PHASES-1:0]   w_green_mask;
  logic                    w_other_pend;
  logic                    w_normal_exit;
  logic                    w_go_yellow;
  logic [PW-1:0]           w_rr_phase;
  logic                    w_rr_found;
  logic [PW-1:0]           w_next_phase;

  assign w_phase_onehot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_q;
  // The active phase does not latch its own demand while it is green
  assign w_green_mask   = (stage_q == ST_GREEN) ? w_phase_onehot : '0;
  assign w_other_pend   = |(pending_q & ~w_phase_onehot);
  assign w_normal_exit  = (timer_q >= C_GMIN_LAST) && w_other_pend &&
                          (!demand[phase_q] || (timer_q == C_GMAX_LAST));

`ifdef SIGNAL_PREEMPT_EN
  logic w_pre_valid;
  // An out-of-range preempt_phase is ignored entirely
  assign w_pre_valid  = preempt &&
                        ({1'b0, preempt_phase} < (PW+1)'(NUM_PHASES));
  assign w_go_yellow  = w_pre_valid ? (phase_q != preempt_phase) : w_normal_exit;
  assign w_next_phase = w_pre_valid ? preempt_phase : w_rr_phase;
`else
  assign w_go_yellow  = w_normal_exit;
  assign w_next_phase = w_rr_phase;
`endif

  // Round-robin search: first pending phase after the active one, else phase 0
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_phase = '0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      if (!w_rr_found && pending_q[(int'(phase_q) + k) % NUM_PHASES]) begin
        w_rr_found = 1'b1;
        w_rr_phase = PW'((int'(phase_q) + k) % NUM_PHASES);
      end
    end
  end

  // Next-state logic for stage, phase, timer and the demand latch
  always_comb begin
    stage_d   = stage_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    pending_d = pending_q | (demand & ~w_green_mask);
    case (stage_q)
      ST_GREEN: begin
        if (w_go_yellow) begin
          stage_d = ST_YELLOW;
          timer_d = '0;
        end else if (timer_q != C_GMAX_LAST) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (timer_q == C_Y_LAST) begin
          stage_d = ST_ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ALLRED: begin
        if (timer_q == C_AR_LAST) begin
          stage_d = ST_GREEN;
          timer_d = '0;
          phase_d = w_next_phase;
          // Entering green services the request; this clear beats a new set
          pending_d[w_next_phase] = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        stage_d   = ST_GREEN;
        phase_d   = '0;
        timer_d   = '0;
        pending_d = '0;
      end
    endcase
  end

  // State register with synchronous reset to phase 0 green
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q   <= ST_GREEN;
      phase_q   <= '0;
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      stage_q   <= stage_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // Light decode: only the active phase can be non-RED, and none in all-red
  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lights
    assign lights[2*i+1:2*i] =
      (phase_q != PW'(i))        ? 2'b00 :
      (stage_q == ST_GREEN)      ? 2'b10 :
      (stage_q == ST_YELLOW)     ? 2'b01 : 2'b00;
  end

  assign active_phase = phase_q;
  assign stage        = stage_q;
  assign pending      = pending_q;

endmodule
`default_nettype wire
